// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer handshake bundle shared by the requesters and the UART transmit arbiter.
// Requester i drives req_data[i*DATA_BITS +: DATA_BITS]; req_ready is a one-hot accept strobe.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmit line among NUM_REQ byte producers.
// Bit timing comes from an external OVERSAMPLE x baud tick; one frame completes before the next grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    uart_tx_arbiter_if.slave           bus,
    output logic                       txd,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TC_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_d;
    logic [TC_W-1:0]      tick_cnt, tick_cnt_d;
    logic [BC_W-1:0]      bit_cnt, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [PTR_W-1:0]     ptr, ptr_d, grant_d, win;
    logic [PTR_W:0]       scan;
    logic                 any_valid, bit_end, txd_d, frame_done_d;
    logic [NUM_REQ-1:0]   ready_oh;
    logic [DATA_BITS-1:0] req_word [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_word[i] = bus.req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    // Scan downward in priority so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        scan      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan = {1'b0, ptr} + (PTR_W+1)'(i);
            if (scan >= (PTR_W+1)'(NUM_REQ)) begin
                scan = scan - (PTR_W+1)'(NUM_REQ);
            end
            if (bus.req_valid[scan[PTR_W-1:0]]) begin
                win       = scan[PTR_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        ready_oh = '0;
        if (state == IDLE && any_valid) begin
            ready_oh[win] = 1'b1;
        end
    end

    assign bus.req_ready = ready_oh;
    assign busy          = (state != IDLE);
    assign bit_end       = tick && (tick_cnt == TC_W'(OVERSAMPLE - 1));

    always_comb begin
        state_d      = state;
        tick_cnt_d   = tick_cnt;
        bit_cnt_d    = bit_cnt;
        shreg_d      = shreg;
        ptr_d        = ptr;
        grant_d      = grant_id;
        frame_done_d = 1'b0;

        if (tick && state != IDLE) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    shreg_d    = req_word[win];
                    grant_d    = win;
                    ptr_d      = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d   = shreg >> 1;
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == BC_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // txd is registered from the next state so each bit edge lands one cycle after its tick.
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            ptr        <= '0;
            grant_id   <= '0;
            txd        <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            tick_cnt   <= tick_cnt_d;
            bit_cnt    <= bit_cnt_d;
            ptr        <= ptr_d;
            grant_id   <= grant_d;
            txd        <= txd_d;
            frame_done <= frame_done_d;
        end
    end

    // Payload register carries no reset; it is always loaded before being shifted out.
    always_ff @(posedge clk) begin
        shreg <= shreg_d;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a tick-count frame model with round-robin grant rules.
// Inputs change on the falling edge; registered outputs are compared on the following falling edge.
module tb_uart_tx_arbiter;
    localparam int N           = 4;
    localparam int DB          = 8;
    localparam int OS          = 16;
    localparam int FRAME_TICKS = OS * (DB + 2);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick;
    logic         txd, busy, frame_done;
    logic [1:0]   grant_id;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_BITS(DB)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .bus        (bus),
        .txd        (txd),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is FRAME_TICKS ticks long, counted from the cycle after acceptance.
    bit           m_busy, m_done;
    int           m_ticks, m_id, m_ptr;
    logic [DB-1:0] m_data;

    logic [N-1:0]  pend, extra, reload_mask;
    logic [DB-1:0] pdata [N];
    int            reload_left, tcnt, done_cnt;
    bit            tick_en, tick_rand;
    int            grant_log[$];
    int            wait_frames [N];
    int            exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s = v >> ((p + k) % N);
            if (s[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic model_txd();
        int b;
        logic [DB-1:0] t;
        if (!m_busy) return 1'b1;
        b = m_ticks / OS;
        if (b == 0) return 1'b0;
        if (b <= DB) begin
            t = m_data >> (b - 1);
            return t[0];
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_ticks = 0; m_id = 0; m_ptr = 0;
    endtask

    task automatic note_grant(input int i);
        grant_log.push_back(i);
        check_val("starve", wait_frames[i] <= N - 1, 1'b1);
        for (int j = 0; j < N; j++) begin
            if (j != i && pend[j]) wait_frames[j]++;
        end
        wait_frames[i] = 0;
        pend[i] = 1'b0;
        if (reload_left > 0 && reload_mask[i]) begin
            pend[i]  = 1'b1;
            pdata[i] = DB'($urandom);
            reload_left--;
        end
    endtask

    task automatic step();
        logic [N-1:0]    cur_valid, exp_rdy, rdy;
        logic [N*DB-1:0] cur_data;
        logic            cur_tick;
        int              w;
        cur_valid = pend | extra;
        for (int i = 0; i < N; i++) cur_data[i*DB +: DB] = pend[i] ? pdata[i] : DB'($urandom);
        tcnt++;
        cur_tick = tick_en && (tick_rand ? ($urandom_range(0, 2) == 0) : (tcnt % 4 == 0));
        bus.req_valid = cur_valid;
        bus.req_data  = cur_data;
        tick          = cur_tick;
        #1;
        w = (rst_n && !m_busy) ? rr_pick(cur_valid, m_ptr) : -1;
        exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
        rdy = bus.req_ready;
        check_val("req_ready", rdy, exp_rdy);
        if (rst_n) begin
            for (int i = 0; i < N; i++) if (rdy[i] && cur_valid[i]) note_grant(i);
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            m_done = 0;
            if (w >= 0) begin
                m_busy  = 1; m_ticks = 0; m_id = w;
                m_data  = DB'(cur_data >> (w * DB));
                m_ptr   = (w + 1) % N;
            end
        end else begin
            m_done = 0;
            if (cur_tick) begin
                m_ticks++;
                if (m_ticks == FRAME_TICKS) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
        @(negedge clk);
        check_val("txd", txd, model_txd());
        check_val("busy", busy, m_busy);
        check_val("grant_id", grant_id, m_id);
        check_val("frame_done", frame_done, m_done);
        if (frame_done) done_cnt++;
    endtask

    task automatic clear_stim();
        pend = '0; extra = '0; reload_mask = '0; reload_left = 0;
        for (int i = 0; i < N; i++) wait_frames[i] = 0;
        grant_log.delete();
        done_cnt = 0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        check_val("rst_txd", txd, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_grant", grant_id, 2'd0);
        check_val("rst_done", frame_done, 1'b0);
        check_val("rst_ready", bus.req_ready, 4'd0);
        model_reset();
        clear_stim();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_until_quiet(input int max_cycles);
        int n = 0;
        while ((m_busy || pend != '0) && n < max_cycles) begin
            step();
            n++;
        end
        check_val("quiet_timeout", n < max_cycles, 1'b1);
    endtask

    task automatic check_log(input string tag);
        check_val({tag, "_len"}, grant_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < grant_log.size(); k++) begin
            check_val(tag, grant_log[k], exp_q[k]);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        tick = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        tick_en = 1'b1; tick_rand = 1'b0; tcnt = 0;
        clear_stim();
        model_reset();
        @(negedge clk);
        #1;
        check_val("init_txd", txd, 1'b1);
        check_val("init_busy", busy, 1'b0);
        check_val("init_grant", grant_id, 2'd0);
        check_val("init_done", frame_done, 1'b0);
        check_val("init_ready", bus.req_ready, 4'd0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();

        // Single byte from requester 0.
        pend[0] = 1'b1; pdata[0] = 8'hA5;
        run_until_quiet(2000);
        exp_q = '{0};
        check_log("s1_grant");
        check_val("s1_done_cnt", done_cnt, 1);

        // All four requesters valid together.
        do_reset();
        pend = 4'hF;
        pdata[0] = 8'h11; pdata[1] = 8'h22; pdata[2] = 8'h33; pdata[3] = 8'h44;
        run_until_quiet(8000);
        exp_q = '{0, 1, 2, 3};
        check_log("s2_grant");
        check_val("s2_done_cnt", done_cnt, 4);

        // Requesters 1 and 3 continuously valid after a grant to 1.
        do_reset();
        pend[1] = 1'b1; pdata[1] = DB'($urandom);
        n = 0;
        while (grant_log.size() == 0 && n < 100) begin step(); n++; end
        check_val("s3_first", grant_log.size(), 1);
        pend[1] = 1'b1; pdata[1] = DB'($urandom);
        pend[3] = 1'b1; pdata[3] = DB'($urandom);
        reload_mask = 4'b1010; reload_left = 3;
        run_until_quiet(8000);
        exp_q = '{1, 3, 1, 3, 1, 3};
        check_log("s3_grant");

        // Tick stalled: start bit holds indefinitely, then completes.
        do_reset();
        tick_en = 1'b0;
        pend[2] = 1'b1; pdata[2] = 8'h5A;
        for (int i = 0; i < 300; i++) step();
        check_val("s4_txd_hold", txd, 1'b0);
        check_val("s4_busy_hold", busy, 1'b1);
        tick_en = 1'b1;
        run_until_quiet(2000);
        check_val("s4_done_cnt", done_cnt, 1);

        // Reset during the 4th data bit; pointer must return to requester 0.
        do_reset();
        pend[2] = 1'b1; pdata[2] = 8'h3C;
        n = 0;
        while (!(m_busy && m_ticks >= 4 * OS + 6) && n < 3000) begin step(); n++; end
        check_val("s5_reach", n < 3000, 1'b1);
        check_val("s5_pre_grant", grant_id, 2'd2);
        do_reset();
        pend[0] = 1'b1; pdata[0] = DB'($urandom);
        pend[3] = 1'b1; pdata[3] = DB'($urandom);
        run_until_quiet(4000);
        exp_q = '{0, 3};
        check_log("s5_grant");

        // One-cycle valid glitch from requester 1 while busy is ignored.
        do_reset();
        pend[0] = 1'b1; pdata[0] = 8'hC3;
        for (int i = 0; i < 20; i++) step();
        extra = 4'b0010;
        step();
        extra = '0;
        run_until_quiet(2000);
        exp_q = '{0};
        check_log("s6_grant");
        check_val("s6_done_cnt", done_cnt, 1);

        // Randomized traffic with irregular ticks and transient valids.
        do_reset();
        tick_rand = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 40) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = DB'($urandom);
                end
            end
            extra = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            step();
        end
        extra = '0;
        run_until_quiet(8000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares a single UART transmit line among NUM_REQ byte producers. It sits downstream of the baud tick generator and consumes its 16x-oversampled tick to time each bit. It accepts one byte at a time from the winning requester and serializes it as 8N1 on txd. Each accepted frame runs to completion before the next grant is issued.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_BITS, 8: bits per frame (5..8).
- OVERSAMPLE, 16: ticks per bit period; must match the tick generator's oversample factor.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tick  input  1  one-cycle pulse at OVERSAMPLE x baud rate.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*DATA_BITS  requester i's data occupies bits [i*DATA_BITS +: DATA_BITS].
- req_ready  output  NUM_REQ  one-hot accept strobe; a transfer occurs when req_valid[i] && req_ready[i].
- txd  output  1  serial line; idle high.
- busy  output  1  a frame is in progress.
- grant_id  output  clog2(NUM_REQ)  index of the requester owning the current or most recent frame.
- frame_done  output  1  one-cycle pulse at the end of the stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - req_ready is combinational and asserted only in IDLE, for exactly one winner.
  - Winner is the first requester with valid set, scanning upward (with wrap) from ptr; ptr is the last granted index + 1.
  - No valid requester means req_ready = 0.
  - On a transfer: latch req_data of the winner into the shift register, set grant_id = winner, set ptr = winner+1 (mod NUM_REQ), clear tick_cnt and bit_cnt, and go to START.
- START: txd = 0. tick_cnt counts ticks. When a tick arrives with tick_cnt == OVERSAMPLE-1, clear tick_cnt and go to DATA.
- DATA:
  - txd = shift register LSB, so bits go out LSB first.
  - At each OVERSAMPLE-th tick, shift right and increment bit_cnt.
  - After DATA_BITS bits, go to STOP.
- STOP:
  - txd = 1.
  - At the OVERSAMPLE-th tick, pulse frame_done and return to IDLE.
- busy = 1 in START, DATA and STOP.
- A requester may deassert valid before being granted; there is no lock-in.
- Data must be stable only in the transfer cycle.
- ticks arriving in IDLE are ignored.
- tick_cnt width is clog2(OVERSAMPLE). bit_cnt width is clog2(DATA_BITS+1). Both wrap only under FSM control.

## Timing
- Reset values: txd = 1, busy = 0, req_ready = 0 (state IDLE, no valid), grant_id = 0, frame_done = 0, ptr = 0. Requester 0 has highest priority after reset.
- txd falls in the first cycle after the transfer cycle; busy rises in that same cycle.
- First bit (start) lasts from acceptance to the OVERSAMPLE-th tick, i.e. between OVERSAMPLE-1 and OVERSAMPLE tick periods. Every following bit is exactly OVERSAMPLE tick periods, measured tick-to-tick.
- Each bit boundary occurs in the cycle after the qualifying tick. txd, state and counters are all registered.
- frame_done is high for the single cycle in which the state returns to IDLE; busy is 0 in that same cycle.
- Back-to-back operation:
  - A pending request is accepted in the first IDLE cycle.
  - The next start bit begins on the following cycle.
  - Minimum stop-to-start gap is one clk cycle beyond the stop bit.
- Simultaneous valids: exactly one req_ready is asserted, per the round-robin order. The others wait with no starvation: every requester is served within NUM_REQ frames.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronously). The partial frame is abandoned and txd returns high.
- A tick coinciding with the transfer cycle is not counted.

## Test plan
- Reset, then drive tick every 4 clk with OVERSAMPLE=16. Requester 0 sends 8'hA5 -> txd emits 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 64 clk except the first (60..64). frame_done pulses once; grant_id = 0.
- Requesters 0..3 all valid from the same cycle with data 8'h11,8'h22,8'h33,8'h44 -> grant order 0,1,2,3. Four complete frames with the matching bytes. Exactly one req_ready is high per acceptance.
- Requesters 1 and 3 continuously valid after a grant to 1 -> grants alternate 3,1,3,1. Requester 1 is never granted twice in a row.
- Hold valid on requester 2 with tick never pulsing -> txd stays 0 in START indefinitely and busy stays 1. Then resume ticks -> the frame completes correctly.
- Assert rst_n = 0 during the 4th data bit -> txd = 1, busy = 0, grant_id = 0 in the same cycle. After release, requester 0 wins over requester 3 when both are valid.
- Requester 1 valid for one IDLE cycle while a frame is busy, then drops -> no req_ready and no frame for requester 1. The ongoing frame is unaffected.
